aes_core_sched: RTL

Round-robin scheduler that shares one `AES_Core` encryption datapath between `NUM_REQ` independent requesters. Each request is accepted via a valid/ready handshake, launched on the core, and answered with the ciphertext, requester id and tag. The block also restarts the core between jobs, because the core's `done` stays latched until reset. It sits between the host-side request ports and the single core instance; the core's `clk` is shared, and its `reset` is driven by `core_reset`.

---
 rtl/aes_pkg.sv | 14 +
 rtl/aes_rr_arbiter.sv | 41 ++++
 rtl/aes_core_sched.sv | 127 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES core scheduler.
package aes_pkg;

   localparam int AES_BLOCK_W = 128;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      LAUNCH,
      BUSY,
      RESPOND
   } sched_state_t;

endpackage

// File: rtl/aes_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from last_grant+1, pointer moves only on advance.
module aes_rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int IW = $clog2(N);

   logic [IW-1:0] last_grant;
   logic [IW-1:0] grant_idx;
   logic          found;
   int            idx;

   always_comb begin
      grant     = '0;
      grant_idx = last_grant;
      found     = 1'b0;
      idx       = 0;
      for (int off = 1; off <= N; off++) begin
         idx = int'(last_grant) + off;
         if (idx >= N) idx = idx - N;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = IW'(idx);
         end
      end
   end

   // Reset to N-1 so requester 0 is searched first.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) last_grant <= IW'(N - 1);
      else if (advance) last_grant <= grant_idx;
   end

endmodule

// File: rtl/aes_core_sched.sv
// Shares one AES core among NUM_REQ requesters: arbitrate, restart the core, launch, collect, respond.
module aes_core_sched
   import aes_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_key,
   input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_plaintext,
   input  logic [NUM_REQ*TAG_W-1:0]       req_tag,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [AES_BLOCK_W-1:0]         rsp_ciphertext,
   output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
   output logic [TAG_W-1:0]               rsp_tag,
   output logic                           rsp_err,
   output logic                           busy,
   output logic [2:0]                     fsm_state,
   output logic                           core_reset,
   output logic                           core_start,
   output logic [AES_BLOCK_W-1:0]         core_key,
   output logic [AES_BLOCK_W-1:0]         core_plaintext,
   input  logic                           core_done,
   input  logic [AES_BLOCK_W-1:0]         core_ciphertext
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   sched_state_t      state;
   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    gidx;
   logic               handshake;
   logic               clear_pulse;
   logic [CNT_W-1:0]   cnt;

   aes_rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req_valid),
      .advance (handshake),
      .grant   (grant)
   );

   always_comb begin
      gidx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) gidx = ID_W'(i);
      end
   end

   // Valid/ready: a request is taken in the cycle where req_valid[i] and req_ready[i] are
   // both high; a response completes in the cycle where rsp_valid and rsp_ready are both high.
   assign handshake  = (state == IDLE) && (|grant);
   assign req_ready  = (state == IDLE && !reset) ? grant : '0;
   assign busy       = (state != IDLE);
   assign fsm_state  = state;
   // The core's done stays latched, so it is reset before every job as well as with the block.
   assign core_reset = reset | clear_pulse;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         clear_pulse    <= 1'b0;
         core_start     <= 1'b0;
         core_key       <= '0;
         core_plaintext <= '0;
         cnt            <= '0;
         rsp_valid      <= 1'b0;
         rsp_ciphertext <= '0;
         rsp_id         <= '0;
         rsp_tag        <= '0;
         rsp_err        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (handshake) begin
                  core_key       <= req_key[int'(gidx)*AES_BLOCK_W +: AES_BLOCK_W];
                  core_plaintext <= req_plaintext[int'(gidx)*AES_BLOCK_W +: AES_BLOCK_W];
                  rsp_tag        <= req_tag[int'(gidx)*TAG_W +: TAG_W];
                  rsp_id         <= gidx;
                  clear_pulse    <= 1'b1;
                  state          <= CLEAR;
               end
            end
            CLEAR: begin
               clear_pulse <= 1'b0;
               core_start  <= 1'b1;
               state       <= LAUNCH;
            end
            LAUNCH: begin
               core_start <= 1'b0;
               cnt        <= '0;
               state      <= BUSY;
            end
            BUSY: begin
               if (core_done) begin
                  rsp_ciphertext <= core_ciphertext;
                  rsp_err        <= 1'b0;
                  rsp_valid      <= 1'b1;
                  state          <= RESPOND;
               end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  rsp_ciphertext <= '0;
                  rsp_err        <= 1'b1;
                  rsp_valid      <= 1'b1;
                  state          <= RESPOND;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESPOND: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
